// File: rtl/adder_pkg.sv
// Shared definitions for the multicycle adder: FSM state encoding and default geometry.
package adder_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_CHUNK = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAdd  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/multicycle_adder_if.sv
// Operand/result handshake bundle for multicycle_adder.
interface multicycle_adder_if
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, ovf
    );
endinterface

// File: rtl/adder_slice.sv
// CHUNK-bit combinational adder slice; also reports the carry into its MSB for overflow detection.
module adder_slice #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_cout,
    output logic             o_msb_cin
);
    logic [CHUNK:0] w_full;

    assign w_full    = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};
    assign o_sum     = w_full[CHUNK-1:0];
    assign o_cout    = w_full[CHUNK];
    // Carry into the MSB recovered from the MSB sum bit and its operands.
    assign o_msb_cin = i_a[CHUNK-1] ^ i_b[CHUNK-1] ^ o_sum[CHUNK-1];
endmodule

// File: rtl/multicycle_adder.sv
// Add/subtract WIDTH-bit operands CHUNK bits per cycle through one reused adder_slice.
// Define MULTICYCLE_ADDER_OVF_EN to register signed overflow on ovf; otherwise ovf is tied low.
module multicycle_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CHUNK = DEF_CHUNK
) (
    input logic                clk,
    input logic                rst,
    multicycle_adder_if.slave  bus
);
    localparam int unsigned NSLICE = WIDTH / CHUNK;
    localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    if (WIDTH % CHUNK != 0) begin : g_bad_param
        $error("multicycle_adder: WIDTH must be a multiple of CHUNK");
    end

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_c_out;
    logic [IDX_W-1:0] r_idx;

    logic [CHUNK-1:0] w_slice_a;
    logic [CHUNK-1:0] w_slice_b;
    logic [CHUNK-1:0] w_slice_sum;
    logic             w_slice_cout;
    logic             w_last;

    assign w_slice_a = r_a[r_idx*CHUNK +: CHUNK];
    assign w_slice_b = r_b[r_idx*CHUNK +: CHUNK];
    assign w_last    = (r_idx == LAST_IDX);

`ifdef MULTICYCLE_ADDER_OVF_EN
    logic w_msb_cin;
    logic r_ovf;
`endif

    adder_slice #(
        .CHUNK (CHUNK)
    ) u_slice (
        .i_a       (w_slice_a),
        .i_b       (w_slice_b),
        .i_cin     (r_carry),
        .o_sum     (w_slice_sum),
        .o_cout    (w_slice_cout),
`ifdef MULTICYCLE_ADDER_OVF_EN
        .o_msb_cin (w_msb_cin)
`else
        .o_msb_cin ()
`endif
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (bus.in_valid)  w_state_next = StAdd;
            StAdd:   if (w_last)        w_state_next = StDone;
            StDone:  if (bus.out_ready) w_state_next = StIdle;
            default:                    w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_c_out <= 1'b0;
            r_idx   <= '0;
        end else begin
            if (r_state == StIdle && bus.in_valid) begin
                // Subtraction folds into addition: a + ~b + ~c_in.
                r_a     <= bus.a;
                r_b     <= bus.b ^ {WIDTH{bus.sub}};
                r_carry <= bus.c_in ^ bus.sub;
                r_idx   <= '0;
            end
            if (r_state == StAdd) begin
                r_sum[r_idx*CHUNK +: CHUNK] <= w_slice_sum;
                r_carry                     <= w_slice_cout;
                r_idx                       <= r_idx + 1'b1;
                if (w_last) begin
                    r_c_out <= w_slice_cout;
                end
            end
        end
    end

`ifdef MULTICYCLE_ADDER_OVF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (r_state == StAdd && w_last) begin
            r_ovf <= w_msb_cin ^ w_slice_cout;
        end
    end
    assign bus.ovf = r_ovf;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.in_ready  = (r_state == StIdle);
    assign bus.out_valid = (r_state == StDone);
    assign bus.sum       = r_sum;
    assign bus.c_out     = r_c_out;
endmodule

// File: tb/tb_multicycle_adder.sv
// Directed self-checking bench: a CHUNK=8 instance for function/latency/hold/reset and a
// CHUNK=32 instance for back-to-back throughput. Honours MULTICYCLE_ADDER_OVF_EN.
module tb_multicycle_adder;
    import adder_pkg::*;

`ifdef MULTICYCLE_ADDER_OVF_EN
    localparam bit OvfEn = 1'b1;
`else
    localparam bit OvfEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    multicycle_adder_if #(.WIDTH(32)) bus8 ();
    multicycle_adder_if #(.WIDTH(32)) bus32 ();

    multicycle_adder #(
        .WIDTH (32),
        .CHUNK (8)
    ) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    multicycle_adder #(
        .WIDTH (32),
        .CHUNK (32)
    ) u_dut32 (
        .clk (clk),
        .rst (rst),
        .bus (bus32)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One transaction on the CHUNK=8 instance; result held for 'hold' cycles with in_valid noise.
    task automatic do_op(input string tag, input logic [31:0] op_a, input logic [31:0] op_b,
                         input logic op_cin, input logic op_sub, input logic [31:0] exp_sum,
                         input logic exp_cout, input logic exp_ovf, input int hold);
        int lat;
        @(negedge clk);
        check_eq({tag, "_in_ready"}, bus8.in_ready, 1);
        bus8.a         = op_a;
        bus8.b         = op_b;
        bus8.c_in      = op_cin;
        bus8.sub       = op_sub;
        bus8.in_valid  = 1'b1;
        bus8.out_ready = 1'b0;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        bus8.a        = 32'hA5A5A5A5;
        bus8.b        = 32'h5A5A5A5A;
        lat = 0;
        while (!bus8.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_latency"}, lat, 4);
        check_eq({tag, "_sum"}, bus8.sum, exp_sum);
        check_eq({tag, "_c_out"}, bus8.c_out, exp_cout);
        check_eq({tag, "_ovf"}, bus8.ovf, exp_ovf & OvfEn);
        for (int i = 0; i < hold; i++) begin
            bus8.in_valid = i[0];
            bus8.a        = 32'hDEAD0000 + i;
            @(negedge clk);
            check_eq({tag, "_hold"}, {bus8.out_valid, bus8.in_ready, bus8.c_out, bus8.sum},
                     {1'b1, 1'b0, exp_cout, exp_sum});
        end
        // Release with in_valid high: the exit edge must not capture it.
        bus8.in_valid  = 1'b1;
        bus8.a         = 32'h0BAD0BAD;
        bus8.out_ready = 1'b1;
        @(negedge clk);
        bus8.in_valid  = 1'b0;
        bus8.out_ready = 1'b0;
        check_eq({tag, "_exit"}, {bus8.in_ready, bus8.out_valid, bus8.c_out, bus8.sum},
                 {1'b1, 1'b0, exp_cout, exp_sum});
    endtask

    logic [31:0] va[3]    = '{32'hFFFFFFFF, 32'h00000005, 32'h7FFFFFFF};
    logic [31:0] vb[3]    = '{32'h00000001, 32'h00000007, 32'h00000001};
    logic        vsub[3]  = '{1'b0, 1'b1, 1'b0};
    logic [31:0] vsum[3]  = '{32'h00000000, 32'hFFFFFFFE, 32'h80000000};
    logic        vcout[3] = '{1'b1, 1'b0, 1'b0};

    initial begin
        int n_acc;
        int n_done;
        int acc_cyc[3];
        bit seen;

        bus8.in_valid   = 1'b0;
        bus8.a          = '0;
        bus8.b          = '0;
        bus8.c_in       = 1'b0;
        bus8.sub        = 1'b0;
        bus8.out_ready  = 1'b0;
        bus32.in_valid  = 1'b0;
        bus32.a         = '0;
        bus32.b         = '0;
        bus32.c_in      = 1'b0;
        bus32.sub       = 1'b0;
        bus32.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_state", {bus8.in_ready, bus8.out_valid, bus8.c_out, bus8.ovf, bus8.sum},
                 {1'b1, 1'b0, 1'b0, 1'b0, 32'h0});

        do_op("wrap",     32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 10);
        do_op("sub",      32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 0);
        do_op("sub_bin",  32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFD, 1'b0, 1'b0, 0);
        do_op("ovf_add",  32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 0);
        do_op("ovf_sub",  32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 0);

        // Reset on the second ADD cycle discards the operation.
        @(negedge clk);
        bus8.a        = 32'h11111111;
        bus8.b        = 32'h22222222;
        bus8.c_in     = 1'b0;
        bus8.sub      = 1'b0;
        bus8.in_valid = 1'b1;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_mid", {bus8.in_ready, bus8.out_valid, bus8.c_out, bus8.ovf, bus8.sum},
                 {1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus8.out_valid) seen = 1'b1;
        end
        check_eq("rst_no_result", seen, 0);

        do_op("carry8",   32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 0);
        do_op("mixed",    32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0, 32'hACF13569, 1'b0, 1'b0, 0);
        do_op("sub_nb",   32'h00000010, 32'h00000001, 1'b0, 1'b1, 32'h0000000F, 1'b1, 1'b0, 0);

        // CHUNK=32: in_valid held high, out_ready high -> accept every third cycle.
        bus32.out_ready = 1'b1;
        n_acc  = 0;
        n_done = 0;
        for (int cyc = 0; cyc < 15; cyc++) begin
            @(negedge clk);
            if (bus32.out_valid) begin
                if (n_done < 3) begin
                    check_eq("c32_sum", bus32.sum, vsum[n_done]);
                    check_eq("c32_c_out", bus32.c_out, vcout[n_done]);
                    check_eq("c32_latency", cyc - acc_cyc[n_done], 2);
                end
                n_done++;
            end
            if (bus32.in_ready) begin
                if (n_acc < 3) begin
                    if (n_acc > 0) check_eq("c32_gap", cyc - acc_cyc[n_acc-1], 3);
                    acc_cyc[n_acc] = cyc;
                    bus32.a        = va[n_acc];
                    bus32.b        = vb[n_acc];
                    bus32.sub      = vsub[n_acc];
                    bus32.c_in     = 1'b0;
                    bus32.in_valid = 1'b1;
                    n_acc++;
                end else begin
                    bus32.in_valid = 1'b0;
                end
            end
        end
        check_eq("c32_done", n_done, 3);
        bus32.in_valid  = 1'b0;
        bus32.out_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/multicycle_adder.md
MULTICYCLE_ADDER -- requirements
Module: multicycle_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and sum width in bits.
REQ-002 SHALL have parameter CHUNK, default 8: bits added per cycle; WIDTH % CHUNK == 0 required; NSLICE = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operands present.
REQ-006 SHALL have port in_ready  output  1  block accepts operands.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port c_in  input  1  carry-in (add) / borrow-in (sub).
REQ-010 SHALL have port sub  input  1  0 = add, 1 = subtract.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  consumer takes result.
REQ-013 SHALL have port sum  output  WIDTH  result.
REQ-014 SHALL have port c_out  output  1  carry-out of MSB.
REQ-015 SHALL have port ovf  output  1  signed overflow (see Configuration).

Function
REQ-016 SHALL implement FSM states IDLE, ADD, DONE.
REQ-017 SHALL assert in_ready only in IDLE; out_valid only in DONE.
REQ-018 In IDLE, in_valid=1 SHALL capture a, b XOR {WIDTH{sub}}, carry = c_in XOR sub, clear slice index, go to ADD.
REQ-019 Result SHALL be {c_out,sum} = a + b + c_in (add) or a + ~b + ~c_in, i.e. a - b - c_in modulo 2^WIDTH (sub); c_out=1 in sub means no borrow.
REQ-020 In ADD, each cycle SHALL add slice [idx*CHUNK +: CHUNK] of captured operands plus carry, write that sum slice, update carry, increment idx.
REQ-021 After slice NSLICE-1, SHALL enter DONE; out_valid SHALL rise exactly NSLICE cycles after the accept edge.
REQ-022 In DONE, out_ready=1 SHALL return to IDLE next cycle; out_ready=0 SHALL hold sum, c_out, ovf and out_valid stable indefinitely.
REQ-023 in_valid, a, b, c_in, sub SHALL be ignored outside IDLE; no operand is accepted in the cycle DONE exits (in_ready rises the following cycle).
REQ-024 sum, c_out, ovf SHALL hold the last result in IDLE until the next accept; partial slices are visible on sum during ADD but meaningful only while out_valid=1.
REQ-025 CHUNK == WIDTH SHALL give one ADD cycle (latency 1).

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE, idx=0, carry=0, sum=0, c_out=0, ovf=0, out_valid=0, in_ready=1 after the edge.
REQ-027 rst SHALL take priority over any handshake; reset mid-ADD or in DONE SHALL discard the operation with no out_valid pulse.

Configuration
REQ-028 Macro MULTICYCLE_ADDER_OVF_EN defined: ovf SHALL be registered at final slice as carry into MSB XOR c_out (two's-complement overflow of the add/sub).
REQ-029 Macro undefined: ovf port SHALL remain, tied to 0, with no overflow logic.

Structure
REQ-030 Package adder_pkg SHALL hold FSM state typedef/encoding (IDLE, ADD, DONE) and default WIDTH/CHUNK constants.
REQ-031 Sub-module adder_slice (CHUNK-bit combinational a+b+cin -> sum, cout, msb carry-in) SHALL be instantiated once and reused per cycle.
REQ-032 Parameter check SHALL fail elaboration when WIDTH % CHUNK != 0.

Verification (WIDTH=32, CHUNK=8 unless stated)
REQ-033 a=FFFFFFFF, b=00000001, c_in=0, sub=0 -> sum=00000000, c_out=1, out_valid exactly 4 cycles after accept.
REQ-034 a=00000005, b=00000007, c_in=0, sub=1 -> sum=FFFFFFFE, c_out=0; repeat with c_in=1 -> sum=FFFFFFFD.
REQ-035 out_ready=0 for 10 cycles after out_valid -> sum, c_out, out_valid stable, in_ready=0 throughout; in_valid pulses ignored.
REQ-036 rst=1 on 2nd ADD cycle -> next cycle IDLE, in_ready=1, out_valid=0, sum=0; no result ever emitted.
REQ-037 With MULTICYCLE_ADDER_OVF_EN: 7FFFFFFF+00000001 -> ovf=1, sum=80000000; 80000000-00000001 (sub) -> ovf=1; without macro ovf=0 for both.
REQ-038 CHUNK=32: back-to-back transactions with out_ready=1 -> out_valid 1 cycle after each accept, one accept per 3 cycles.
